i2c_slave_regs: RTL and testbench
=================================

I2C_SLAVE_REGS -- requirements
Module: i2c_slave_regs

Interface
REQ-001 The block SHALL have parameter DEV_ADDR, default 7'h68: 7-bit I2C target address it responds to.
REQ-002 The block SHALL have parameter NUM_REGS, default 8: register file depth; power of two, range 2..256.
REQ-003 clk  in  1  single clock; all logic on its rising edge; SHALL be at least 20x the SCL rate.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 scl_s2m  in  1  raw SCL line level (asynchronous).
REQ-006 sda_s2m  in  1  raw SDA line level (asynchronous).
REQ-007 sda_oen_n  out  1  0 = pull SDA low, 1 = release; the pad applies it open-drain.
REQ-008 host_addr  in  $clog2(NUM_REGS)  host-side register read address.
REQ-009 host_rdata  out  8  combinational read of regs[host_addr].
REQ-010 wr_pulse  out  1  one-cycle strobe per committed I2C write byte.
REQ-011 wr_addr  out  $clog2(NUM_REGS)  register written; valid with wr_pulse.
REQ-012 wr_data  out  8  byte written; valid with wr_pulse.

Function
REQ-013 SCL and SDA SHALL each pass through a 2-flop synchronizer; all edge detection uses the synchronized values (2-cycle input latency).
REQ-014 START = SDA falling while SCL high; STOP = SDA rising while SCL high; both SHALL be honoured in any state, including mid-byte.
REQ-015 States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
REQ-016 START (including repeated START) -> ADDR with bit counter cleared; STOP -> IDLE with SDA released.
REQ-017 Bits SHALL be sampled on the synchronized SCL rising edge, MSB first; SDA SHALL change only on the synchronized SCL falling edge.
REQ-018 ADDR: after 8 bits, address match -> ADDR_ACK; mismatch -> IGNORE (SDA released until next START/STOP).
REQ-019 ACK: sda_oen_n=0 from the SCL fall after bit 8 until the SCL fall after bit 9.
REQ-020 ADDR_ACK exit: R/W=0 -> PTR; R/W=1 -> RDATA, loading regs[ptr] for shifting out.
REQ-021 PTR: received byte modulo NUM_REGS -> ptr; ACK; then WDATA.
REQ-022 WDATA: after 8 bits, regs[ptr] <= byte and wr_pulse/wr_addr/wr_data assert for exactly one cycle; ACK; ptr increments.
REQ-023 RDATA: drive shift-register MSB per bit (release SDA for 1, pull low for 0); in RDATA_ACK release SDA and sample master ACK on SCL rise.
REQ-024 Master ACK (SDA=0) -> ptr increments, next byte loads, -> RDATA; NACK -> IGNORE.
REQ-025 ptr SHALL wrap from NUM_REGS-1 to 0 on increment.
REQ-026 ptr SHALL persist across transactions, so write-pointer-then-repeated-START-read reads from the set pointer.
REQ-027 A START or STOP arriving mid-byte SHALL discard the partial byte; no register update and no wr_pulse.
REQ-028 No clock stretching: SCL is never driven.

Reset
REQ-029 Reset SHALL set: state=IDLE, sda_oen_n=1, wr_pulse=0, wr_addr=0, wr_data=0, ptr=0, all regs=8'h00, synchronizers=1 (bus idle).
REQ-030 Reset asserted mid-transaction SHALL release SDA immediately (asynchronously); after release the block waits for a fresh START.

Structure
REQ-031 The state enum and the I2C bit/ACK constants SHALL live in the shared package i2c_pkg, alongside the master's definitions.
REQ-032 START/STOP/edge detection SHALL be one sub-module, i2c_line_sync (synchronizers plus scl_rise, scl_fall, start, stop outputs).

Verification
REQ-033 Write: START, 0xD0, 0x03, 0xA5, STOP -> three ACKs; wr_pulse once with wr_addr=3, wr_data=0xA5; host_addr=3 reads 0xA5.
REQ-034 Random read: START, 0xD0, 0x07, rSTART, 0xD1, read 2 bytes (ACK then NACK) -> bytes returned are regs[7] then regs[0] (wrap).
REQ-035 Wrong address: START, 0xA0, 0x00 -> SDA never pulled low; no wr_pulse; state returns IDLE on STOP.
REQ-036 Abort: START, 0xD0, 0x01, 4 data bits then STOP -> no wr_pulse; regs[1] unchanged; next transaction ACKs normally.
REQ-037 Reset mid-read, while driving a 0 bit -> sda_oen_n=1 within the reset cycle; the first STOP/START afterwards is handled cleanly.
REQ-038 Burst write of 9 bytes from ptr 0 with NUM_REGS=8 -> regs[0] holds the 9th byte; 9 wr_pulses with wr_addr sequence 0..7,0.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target state encoding, line levels and bit/ACK constants.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_IGNORE
    } i2c_slv_state_e;

    typedef enum logic [2:0] {
        MST_IDLE,
        MST_START,
        MST_BIT,
        MST_ACK,
        MST_STOP
    } i2c_mst_state_e;

    localparam logic       I2C_ACK     = 1'b0;
    localparam logic       I2C_NACK    = 1'b1;
    localparam logic       SDA_PULL    = 1'b0;
    localparam logic       SDA_RELEASE = 1'b1;
    localparam logic [3:0] I2C_BITS    = 4'd8;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizers for SCL/SDA plus bus edge, START and STOP detection.
module i2c_line_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_prev_q, sda_prev_q;
    logic       scl;

    // Reset to the idle-bus level so no spurious edge fires after reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
            scl_prev_q <= scl_sync_q[1];
            sda_prev_q <= sda_sync_q[1];
        end
    end

    assign scl        = scl_sync_q[1];
    assign sda_o      = sda_sync_q[1];
    assign scl_rise_o = scl & ~scl_prev_q;
    assign scl_fall_o = ~scl & scl_prev_q;
    assign start_o    = scl & scl_prev_q & sda_prev_q & ~sda_o;
    assign stop_o     = scl & scl_prev_q & ~sda_prev_q & sda_o;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C target exposing a byte register file: pointer write, burst write, burst read.
module i2c_slave_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h68,
    parameter int         NUM_REGS = 8,
    localparam int        AW       = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scl_s2m,
    input  logic          sda_s2m,
    output logic          sda_oen_n,
    input  logic [AW-1:0] host_addr,
    output logic [7:0]    host_rdata,
    output logic          wr_pulse,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data
);

    i2c_slv_state_e state_q, state_d;
    logic [3:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic [AW-1:0]  ptr_q, ptr_d, ptr_inc;
    logic           sda_oen_q, sda_oen_d;
    logic           rw_q, rw_d, mack_q, mack_d;
    logic           wr_pulse_q, wr_pulse_d;
    logic [AW-1:0]  wr_addr_q, wr_addr_d;
    logic [7:0]     wr_data_q, wr_data_d;
    logic           reg_we;
    logic [7:0]     regs_q [NUM_REGS];

    logic sda, scl_rise, scl_fall, start, stop;
    logic byte_done, addr_hit;

    i2c_line_sync u_sync (
        .clk_i      (clk),
        .rst_i      (rst),
        .scl_i      (scl_s2m),
        .sda_i      (sda_s2m),
        .sda_o      (sda),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start),
        .stop_o     (stop)
    );

    assign byte_done = scl_fall && (bit_cnt_q == I2C_BITS);
    assign addr_hit  = (shift_q[7:1] == DEV_ADDR);
    assign ptr_inc   = ptr_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (stop) state_d = ST_IDLE;
        else if (start) state_d = ST_ADDR;
        else begin
            case (state_q)
                ST_ADDR:      if (byte_done) state_d = addr_hit ? ST_ADDR_ACK : ST_IGNORE;
                ST_ADDR_ACK:  if (scl_fall) state_d = rw_q ? ST_RDATA : ST_PTR;
                ST_PTR:       if (byte_done) state_d = ST_PTR_ACK;
                ST_PTR_ACK,
                ST_WDATA_ACK: if (scl_fall) state_d = ST_WDATA;
                ST_WDATA:     if (byte_done) state_d = ST_WDATA_ACK;
                ST_RDATA:     if (byte_done) state_d = ST_RDATA_ACK;
                ST_RDATA_ACK: if (scl_fall) state_d = (mack_q == I2C_ACK) ? ST_RDATA : ST_IGNORE;
                default:      state_d = state_q;
            endcase
        end
    end

    // Shifting happens on every SCL rise in byte states; in RDATA the MSB
    // is the bit just sent, so the fall that follows drives the new MSB.
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        sda_oen_d  = sda_oen_q;
        rw_d       = rw_q;
        mack_d     = mack_q;
        wr_pulse_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        reg_we     = 1'b0;
        if (stop || start) begin
            sda_oen_d = SDA_RELEASE;
            bit_cnt_d = '0;
        end else begin
            if (scl_rise && (state_q inside {ST_ADDR, ST_PTR, ST_WDATA, ST_RDATA})) begin
                shift_d   = {shift_q[6:0], sda};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
            case (state_q)
                ST_ADDR: if (byte_done && addr_hit) begin
                    sda_oen_d = SDA_PULL;
                    rw_d      = shift_q[0];
                end
                ST_ADDR_ACK: if (scl_fall) begin
                    bit_cnt_d = '0;
                    if (rw_q) begin
                        shift_d   = regs_q[ptr_q];
                        sda_oen_d = regs_q[ptr_q][7];
                    end else begin
                        sda_oen_d = SDA_RELEASE;
                    end
                end
                ST_PTR: if (byte_done) begin
                    ptr_d     = shift_q[AW-1:0];
                    sda_oen_d = SDA_PULL;
                end
                ST_PTR_ACK, ST_WDATA_ACK: if (scl_fall) begin
                    sda_oen_d = SDA_RELEASE;
                    bit_cnt_d = '0;
                end
                ST_WDATA: if (byte_done) begin
                    reg_we     = 1'b1;
                    wr_pulse_d = 1'b1;
                    wr_addr_d  = ptr_q;
                    wr_data_d  = shift_q;
                    ptr_d      = ptr_inc;
                    sda_oen_d  = SDA_PULL;
                end
                ST_RDATA: if (scl_fall) sda_oen_d = byte_done ? SDA_RELEASE : shift_q[7];
                ST_RDATA_ACK: begin
                    if (scl_rise) mack_d = sda;
                    if (scl_fall) begin
                        if (mack_q == I2C_ACK) begin
                            ptr_d     = ptr_inc;
                            shift_d   = regs_q[ptr_inc];
                            sda_oen_d = regs_q[ptr_inc][7];
                            bit_cnt_d = '0;
                        end else begin
                            sda_oen_d = SDA_RELEASE;
                        end
                    end
                end
                default: sda_oen_d = SDA_RELEASE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            ptr_q      <= '0;
            sda_oen_q  <= SDA_RELEASE;
            rw_q       <= 1'b0;
            mack_q     <= I2C_NACK;
            wr_pulse_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            sda_oen_q  <= sda_oen_d;
            rw_q       <= rw_d;
            mack_q     <= mack_d;
            wr_pulse_q <= wr_pulse_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            if (reg_we) regs_q[ptr_q] <= shift_q;
        end
    end

    assign sda_oen_n  = sda_oen_q;
    assign wr_pulse   = wr_pulse_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign host_rdata = regs_q[host_addr];

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench: bus-level master tasks, transaction model of regs/ptr, per-cycle output compare.
module tb_i2c_slave_regs;

    localparam int NR = 8;
    localparam int Q  = 20;
    localparam int H  = 5;

    logic       clk, rst, scl_m, sda_m;
    logic       sda_oen_n, wr_pulse;
    logic [2:0] host_addr, wr_addr;
    logic [7:0] host_rdata, wr_data;
    wire        sda_line = sda_m & sda_oen_n;

    i2c_slave_regs #(.DEV_ADDR(7'h68), .NUM_REGS(NR)) dut (
        .clk        (clk),
        .rst        (rst),
        .scl_s2m    (scl_m),
        .sda_s2m    (sda_line),
        .sda_oen_n  (sda_oen_n),
        .host_addr  (host_addr),
        .host_rdata (host_rdata),
        .wr_pulse   (wr_pulse),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks = 0, failures = 0, pulses = 0;
    logic [7:0] mregs [NR];
    int         mptr;
    int         exp_a[$];
    logic [7:0] exp_d[$];
    logic       reg_chk = 1'b0, pulled = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_cyc(H);
        scl_m = 1'b1; wait_cyc(Q);
        sda_m = 1'b0; wait_cyc(Q);
        scl_m = 1'b0; wait_cyc(H);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_cyc(H);
        scl_m = 1'b1; wait_cyc(Q);
        sda_m = 1'b1; wait_cyc(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, input int nbits, output logic ack);
        logic [7:0] sh;
        sh  = b;
        ack = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            sda_m = sh[7];
            sh    = sh << 1;
            wait_cyc(Q); scl_m = 1'b1;
            wait_cyc(Q); scl_m = 1'b0;
            wait_cyc(H);
        end
        if (nbits == 8) begin
            sda_m = 1'b1;
            wait_cyc(Q); scl_m = 1'b1;
            wait_cyc(Q/2); ack = sda_line;
            wait_cyc(Q/2); scl_m = 1'b0;
            wait_cyc(H);
        end
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] b);
        b = '0;
        sda_m = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_cyc(Q); scl_m = 1'b1;
            wait_cyc(Q/2); b = {b[6:0], sda_line};
            wait_cyc(Q/2); scl_m = 1'b0;
            wait_cyc(H);
        end
        sda_m = mack;
        wait_cyc(Q); scl_m = 1'b1;
        wait_cyc(Q); scl_m = 1'b0;
        wait_cyc(H); sda_m = 1'b1;
    endtask

    // Pointer write followed by n data bytes base, base+step, ...
    task automatic wr_txn(input logic [7:0] p, input int n, input logic [7:0] base, input logic [7:0] step);
        logic       ack;
        logic [7:0] d;
        i2c_start();
        send_byte(8'hD0, 8, ack); chk("wr_addr_ack", ack, 0);
        send_byte(p, 8, ack);     chk("wr_ptr_ack", ack, 0);
        mptr = p % NR;
        for (int i = 0; i < n; i++) begin
            d = 8'(base + i * step);
            exp_a.push_back(mptr);
            exp_d.push_back(d);
            send_byte(d, 8, ack); chk("wr_data_ack", ack, 0);
            mregs[mptr] = d;
            mptr = (mptr + 1) % NR;
        end
        i2c_stop();
    endtask

    // Pointer set, repeated START, read two bytes (ACK then NACK).
    task automatic rd2_txn(input logic [7:0] p, output logic [7:0] b0, output logic [7:0] b1);
        logic ack;
        i2c_start();
        send_byte(8'hD0, 8, ack); chk("rd_addrw_ack", ack, 0);
        send_byte(p, 8, ack);     chk("rd_ptr_ack", ack, 0);
        mptr = p % NR;
        i2c_start();
        send_byte(8'hD1, 8, ack); chk("rd_addrr_ack", ack, 0);
        read_byte(1'b0, b0);      chk("rd_byte0", b0, mregs[mptr]);
        mptr = (mptr + 1) % NR;
        read_byte(1'b1, b1);      chk("rd_byte1", b1, mregs[mptr]);
        i2c_stop();
    endtask

    task automatic sweep_regs();
        for (int a = 0; a < NR; a++) begin
            @(posedge clk); host_addr = 3'(a); reg_chk = 1'b1;
            @(negedge clk);
        end
        @(posedge clk); reg_chk = 1'b0;
    endtask

    task automatic host_rd(input logic [2:0] a, input logic [7:0] exp, input string nm);
        @(posedge clk); host_addr = a;
        @(negedge clk); chk(nm, host_rdata, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack;
        logic [7:0] b0, b1;
        int         p0;
        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; host_addr = '0;
        for (int i = 0; i < NR; i++) mregs[i] = 8'h00;
        mptr = 0;
        fork
            forever begin
                @(negedge clk);
                if (wr_pulse) begin
                    pulses++;
                    if (exp_a.size() == 0) chk("wr_pulse_unexpected", 1, 0);
                    else begin
                        chk("wr_addr", wr_addr, exp_a.pop_front());
                        chk("wr_data", wr_data, exp_d.pop_front());
                    end
                end
                if (!sda_oen_n) pulled = 1'b1;
                if (reg_chk) chk("host_rdata", host_rdata, mregs[host_addr]);
            end
            begin
                wait_cyc(3);
                chk("rst_sda_oen_n", sda_oen_n, 1);
                chk("rst_wr_pulse", wr_pulse, 0);
                chk("rst_wr_addr", wr_addr, 0);
                chk("rst_wr_data", wr_data, 0);
                rst = 1'b0;
                wait_cyc(3);
                sweep_regs();

                // single write to reg 3
                p0 = pulses;
                wr_txn(8'h03, 1, 8'hA5, 8'h00);
                chk("w1_pulses", pulses - p0, 1);
                host_rd(3'd3, 8'hA5, "w1_reg3");

                // random read across the wrap point
                wr_txn(8'h07, 2, 8'h3C, 8'h87);
                rd2_txn(8'h07, b0, b1);
                chk("rr_lit_b0", b0, 8'h3C);
                chk("rr_lit_b1", b1, 8'hC3);

                // wrong device address
                pulled = 1'b0; p0 = pulses;
                i2c_start();
                send_byte(8'hA0, 8, ack); chk("wa_addr_nack", ack, 1);
                send_byte(8'h00, 8, ack); chk("wa_data_nack", ack, 1);
                i2c_stop();
                chk("wa_no_pull", pulled, 0);
                chk("wa_no_pulse", pulses - p0, 0);

                // abort mid data byte
                p0 = pulses;
                i2c_start();
                send_byte(8'hD0, 8, ack); chk("ab_addr_ack", ack, 0);
                send_byte(8'h01, 8, ack); chk("ab_ptr_ack", ack, 0);
                send_byte(8'hF0, 4, ack);
                i2c_stop();
                chk("ab_no_pulse", pulses - p0, 0);
                host_rd(3'd1, 8'h00, "ab_reg1");
                wr_txn(8'h04, 1, 8'h5A, 8'h00);
                sweep_regs();

                // 9-byte burst wraps onto reg 0
                p0 = pulses;
                wr_txn(8'h00, 9, 8'h10, 8'h01);
                chk("bw_pulses", pulses - p0, 9);
                host_rd(3'd0, 8'h18, "bw_reg0");
                host_rd(3'd7, 8'h17, "bw_reg7");
                sweep_regs();

                // reset while the target drives a 0 data bit
                wr_txn(8'h02, 1, 8'h00, 8'h00);
                i2c_start();
                send_byte(8'hD0, 8, ack); chk("rs_addr_ack", ack, 0);
                send_byte(8'h02, 8, ack); chk("rs_ptr_ack", ack, 0);
                i2c_start();
                send_byte(8'hD1, 8, ack); chk("rs_addrr_ack", ack, 0);
                wait_cyc(4);
                chk("rs_driving0", sda_oen_n, 0);
                rst = 1'b1;
                #1 chk("rs_async_release", sda_oen_n, 1);
                for (int i = 0; i < NR; i++) mregs[i] = 8'h00;
                mptr = 0;
                wait_cyc(3);
                rst = 1'b0;
                wait_cyc(3);
                i2c_stop();
                p0 = pulses;
                wr_txn(8'h05, 1, 8'h77, 8'h00);
                chk("rs_post_pulses", pulses - p0, 1);
                host_rd(3'd5, 8'h77, "rs_reg5");
                sweep_regs();

                chk("exp_queue_empty", exp_a.size(), 0);
            end
        join_any
        disable fork;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
